// File: rtl/roll_pkg.sv
// Shared types and constants for the roll history block.
//   state_t   : browse FSM state (S_LIVE, S_BROWSE), 1-bit encoding
//   DW_DEF    : default roll result width
//   DEPTH_DEF : default number of stored results
//   ptr_w()   : pointer/offset width for a given DEPTH
//   cnt_w()   : entry-count width for a given DEPTH (must hold DEPTH itself)
package roll_pkg;

  typedef enum logic {
    S_LIVE   = 1'b0,
    S_BROWSE = 1'b1
  } state_t;

  localparam int DW_DEF    = 4;
  localparam int DEPTH_DEF = 8;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/history_ram.sv
// DEPTH x DW register file holding the roll history.
// One synchronous write port and one combinational read port. The storage
// has no reset; the owner masks it until an entry has been written.
//   clk   : system clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module history_ram #(
  parameter int DEPTH = 8,
  parameter int DW    = 4,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/roll_history.sv
// Roll history: captures each settled roll into a ring buffer of the most
// recent DEPTH results and lets the user browse older entries with prev/next
// key pulses. The selected entry is presented to the seven-segment path.
//
// Optional feature macro: ROLL_HISTORY_CLEAR_EN adds i_clear, a synchronous
// one-cycle clear of the history (priority over valid and keys).
//
// Ports:
//   i_clk     : system clock
//   i_rst_n   : asynchronous active-low reset
//   i_valid   : one-cycle strobe, roll value on i_data
//   i_data    : roll result
//   i_prev    : one-cycle pulse, step to an older entry
//   i_next    : one-cycle pulse, step to a newer entry
//   i_clear   : (ROLL_HISTORY_CLEAR_EN only) synchronous clear
//   o_data    : displayed entry (registered)
//   o_index   : browse offset, 0 = newest (registered)
//   o_count   : number of valid entries, saturates at DEPTH (registered)
//   o_empty   : high when o_count is 0 (registered)
//   o_browse  : high while browsing older entries (registered)
//
// state    | meaning
// S_LIVE   | offset 0, display follows the newest entry
// S_BROWSE | offset >= 1, display holds an older entry
module roll_history
  import roll_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF,
  localparam int AW   = ptr_w(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic          i_prev,
  input  logic          i_next,
`ifdef ROLL_HISTORY_CLEAR_EN
  input  logic          i_clear,
`endif
  output logic [DW-1:0] o_data,
  output logic [AW-1:0] o_index,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_browse
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] OFF_MAX = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] off_q, off_d;
  logic [AW-1:0] off_a;
  logic          key_prev, key_next;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;

  history_ram #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_ram (
    .clk   (i_clk),
    .we    (i_valid),
    .waddr (wp_q),
    .wdata (i_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Next state: the write and its offset shift are applied first, then the
  // key step works on the post-write offset and count.
  always_comb begin
    state_d  = state_q;
    wp_d     = wp_q;
    cnt_d    = cnt_q;
    off_a    = off_q;
    key_prev = i_prev & ~i_next;
    key_next = i_next & ~i_prev;

    if (i_valid) begin
      wp_d = wp_q + AW'(1);
      if (cnt_q != DEPTH_C) cnt_d = cnt_q + CW'(1);
      // Keep the viewed entry on screen; if it was just overwritten, fall
      // back to the oldest survivor.
      if (state_q == S_BROWSE && off_q != OFF_MAX) off_a = off_q + AW'(1);
    end

    if (state_q == S_LIVE) begin
      if (key_prev && cnt_d >= CW'(2)) begin
        state_d = S_BROWSE;
        off_a   = AW'(1);
      end
    end else begin
      if (key_prev) begin
        if (CW'(off_a) + CW'(1) < cnt_d) off_a = off_a + AW'(1);
      end else if (key_next) begin
        off_a = off_a - AW'(1);
        if (off_a == '0) state_d = S_LIVE;
      end
    end

    off_d = off_a;

`ifdef ROLL_HISTORY_CLEAR_EN
    if (i_clear) begin
      state_d = S_LIVE;
      wp_d    = '0;
      cnt_d   = '0;
      off_d   = '0;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_LIVE;
      wp_q    <= '0;
      cnt_q   <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
    end
  end

  // Power-of-two DEPTH makes the AW-bit subtraction wrap modulo DEPTH.
  assign raddr = wp_q - AW'(1) - off_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data   <= '0;
      o_index  <= '0;
      o_count  <= '0;
      o_empty  <= 1'b1;
      o_browse <= 1'b0;
    end else begin
      o_data   <= (cnt_q == '0) ? '0 : rdata;
      o_index  <= off_q;
      o_count  <= cnt_q;
      o_empty  <= (cnt_q == '0);
      o_browse <= (state_q == S_BROWSE);
    end
  end

endmodule
